// File: rtl/ofdm_pkg.sv
// -----------------------------------------------------------------------------
// ofdm_pkg
// Constants and types shared by the OFDM transmit and receive sides of the SPI
// DAC link: sample width, FFT size, cyclic-prefix length, symbol length, the
// width of the in-symbol index, and the SPI frame FSM state encodings.
// -----------------------------------------------------------------------------
package ofdm_pkg;

    localparam int DATA_W  = 16;          // bits per SPI frame / sample
    localparam int N       = 8;           // useful samples per symbol
    localparam int CP      = 4;           // cyclic-prefix samples per symbol
    localparam int SYM_LEN = N + CP;      // words per symbol on the wire
    localparam int INDEX_W = 8;           // width of the useful-sample index

    localparam int POS_W = $clog2(SYM_LEN);
    // Bit counter must reach DATA_W+1 so an over-long frame is distinguishable.
    localparam int CNT_W = $clog2(DATA_W + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } frame_state_t;

    // Symbol position successor, wrapping after the last word of a symbol.
    function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p);
        return (p == POS_W'(SYM_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/ofdm_spi_rx_deframer_if.sv
// -----------------------------------------------------------------------------
// ofdm_spi_rx_deframer_if
// Valid/ready sample stream carrying one useful OFDM sample per transfer.
//   m_data  : received sample
//   m_index : position of the sample within the useful part of the symbol
//   m_valid : data/index/last are valid
//   m_last  : marks index N-1
//   m_ready : sink accepts when m_valid && m_ready
// master = producer (deframer), slave = consumer (FFT front end).
// -----------------------------------------------------------------------------
interface ofdm_spi_rx_deframer_if;
    import ofdm_pkg::*;

    logic [DATA_W-1:0]  m_data;
    logic [INDEX_W-1:0] m_index;
    logic               m_valid;
    logic               m_last;
    logic               m_ready;

    modport master (output m_data, m_index, m_valid, m_last, input  m_ready);
    modport slave  (input  m_data, m_index, m_valid, m_last, output m_ready);

endinterface

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous input, followed by rise/fall
// detection on the synchronised level. Flops reset to IDLE_VAL so that the
// idle line level does not look like an edge when reset is released.
// Ports:
//   clk, reset : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   level      : synchronised level
//   rise, fall : one-cycle pulses on synchronised edges
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: non-blocking assignments here so every flop samples the pre-edge
    // value of its neighbour; blocking would collapse the chain into one stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{IDLE_VAL}};
            prev_q <= IDLE_VAL;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(din);
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/ofdm_spi_rx_deframer.sv
// -----------------------------------------------------------------------------
// ofdm_spi_rx_deframer
// SPI responder for the transmitter's DAC link. Deserialises DATA_W-bit
// MSB-first frames, tracks the word position within each OFDM symbol, drops
// the cyclic prefix and emits the N useful samples as a valid/ready stream
// with index and last.
// Ports:
//   clk, reset        : system clock (>= 4x sclk), async active-low reset
//   sclk, cs_n, mosi  : SPI link, asynchronous to clk
//   resync            : one-cycle pulse; next complete word is position 0
//   m (master)        : m_data / m_index / m_valid / m_last / m_ready
//   frame_err         : pulse, frame closed with bit count != DATA_W
//   overrun           : pulse, useful word dropped due to backpressure
// -----------------------------------------------------------------------------
module ofdm_spi_rx_deframer
    import ofdm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sclk,
    input  logic                   cs_n,
    input  logic                   mosi,
    input  logic                   resync,
    ofdm_spi_rx_deframer_if.master m,
    output logic                   frame_err,
    output logic                   overrun
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .din(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_level, sclk_fall, cs_level};

    // mosi gets the same depth as sclk, so at a synchronised sclk rise the
    // synchronised mosi is the bit that was on the wire at the real edge.
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mosi_sync_q <= '0;
        else        mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    frame_state_t      state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [POS_W-1:0]  pos;
    logic              resync_pend;
    logic [POS_W-1:0]  word_pos;

    // A resync in the COMMIT cycle itself already applies to the committing word.
    assign word_pos = (resync || resync_pend) ? '0 : pos;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            pos         <= '0;
            resync_pend <= 1'b0;
            m.m_data    <= '0;
            m.m_index   <= '0;
            m.m_valid   <= 1'b0;
            m.m_last    <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (m.m_valid && m.m_ready) m.m_valid <= 1'b0;
            if (resync)                 resync_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shift_q <= '0;
                    end
                end

                SHIFT: begin
                    if (sclk_rise) begin
                        shift_q <= {shift_q[DATA_W-2:0], mosi_s};
                        if (bit_cnt != CNT_W'(DATA_W + 1)) bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (cs_rise) state <= COMMIT;
                end

                COMMIT: begin
                    state <= IDLE;
                    if (bit_cnt == CNT_W'(DATA_W)) begin
                        pos         <= next_pos(word_pos);
                        resync_pend <= 1'b0;
                        if (word_pos >= POS_W'(CP)) begin
                            // Position advances even when the word is dropped,
                            // keeping symbol alignment under backpressure.
                            if (!m.m_valid || m.m_ready) begin
                                m.m_data  <= shift_q;
                                m.m_index <= INDEX_W'(word_pos - POS_W'(CP));
                                m.m_last  <= (word_pos == POS_W'(SYM_LEN - 1));
                                m.m_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_spi_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_ofdm_spi_rx_deframer
// Directed bench: SPI frames are bit-banged on negedge-aligned timing with
// sclk = clk/8; accepted stream beats are captured into a queue on the falling
// clock edge and compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_ofdm_spi_rx_deframer;
    import ofdm_pkg::*;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic sclk   = 1'b0;
    logic cs_n   = 1'b1;
    logic mosi   = 1'b0;
    logic resync = 1'b0;
    logic frame_err, overrun;

    ofdm_spi_rx_deframer_if s_if ();

    ofdm_spi_rx_deframer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .resync(resync), .m(s_if), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  index;
        logic        last;
    } out_t;

    typedef struct {
        logic [15:0] tx;
        bit          exp_out;
        logic [7:0]  exp_index;
        bit          exp_last;
    } vec_t;

    out_t got_q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt  = 0;

    // Stream monitor: m_ready only changes just after a rising edge, so a
    // beat seen here with valid && ready is transferred on the next edge.
    always @(negedge clk) begin
        if (s_if.m_valid && s_if.m_ready)
            got_q.push_back('{s_if.m_data, s_if.m_index, s_if.m_last});
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_bit(input logic b);
        mosi = b;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    // One frame of nbits, MSB first, then a gap long enough for the word
    // to reach and leave the output register.
    task automatic send_word(input logic [15:0] w, input int nbits = 16);
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) sclk_bit(w[15-i]);
        wait_clk(4);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(12);
    endtask

    task automatic expect_out(input string tag, input bit exp_out, input logic [15:0] d,
                              input logic [7:0] idx, input bit last);
        out_t g;
        check({tag, ".count"}, got_q.size(), {31'd0, exp_out});
        if (exp_out && got_q.size() != 0) begin
            g = got_q.pop_front();
            check({tag, ".data"},  g.data,  d);
            check({tag, ".index"}, g.index, idx);
            check({tag, ".last"},  g.last,  last);
        end
        got_q.delete();
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 s_if.m_ready = r;
    endtask

    vec_t t1[12];

    initial begin
        t1[0]  = '{16'h0100, 0, 8'd0, 0};  t1[1]  = '{16'h0101, 0, 8'd0, 0};
        t1[2]  = '{16'h0102, 0, 8'd0, 0};  t1[3]  = '{16'h0103, 0, 8'd0, 0};
        t1[4]  = '{16'h0104, 1, 8'd0, 0};  t1[5]  = '{16'h0105, 1, 8'd1, 0};
        t1[6]  = '{16'h0106, 1, 8'd2, 0};  t1[7]  = '{16'h0107, 1, 8'd3, 0};
        t1[8]  = '{16'h0108, 1, 8'd4, 0};  t1[9]  = '{16'h0109, 1, 8'd5, 0};
        t1[10] = '{16'h010A, 1, 8'd6, 0};  t1[11] = '{16'h010B, 1, 8'd7, 1};

        s_if.m_ready = 1'b0;

        // Reset state
        wait_clk(3);
        check("rst.valid", s_if.m_valid, 0);
        check("rst.data",  s_if.m_data,  0);
        check("rst.index", s_if.m_index, 0);
        check("rst.last",  s_if.m_last,  0);
        check("rst.ferr",  frame_err,    0);
        check("rst.ovr",   overrun,      0);
        reset = 1'b1;
        s_if.m_ready = 1'b1;
        wait_clk(5);

        // One symbol from the table: CP dropped, 8 useful words
        for (int i = 0; i < 12; i++) begin
            send_word(t1[i].tx);
            expect_out("t1", t1[i].exp_out, t1[i].tx, t1[i].exp_index, t1[i].exp_last);
        end
        check("t1.ferr", ferr_cnt, 0);

        // Two back-to-back symbols, index wraps between them
        for (int k = 0; k < 24; k++) begin
            send_word(16'(k));
            expect_out("t2", (k % 12) >= 4, 16'(k), 8'((k % 12) - 4), (k % 12) == 11);
        end

        // Short frame at pos 5 leaves the position unchanged
        for (int k = 0; k < 5; k++) begin
            send_word(16'h3000 + 16'(k));
            expect_out("t3.pre", k == 4, 16'h3004, 8'd0, 0);
        end
        send_word(16'h3BAD, 12);
        check("t3.ferr", ferr_cnt, 1);
        expect_out("t3.bad", 0, 16'h0, 8'd0, 0);
        send_word(16'h3005);
        expect_out("t3.after", 1, 16'h3005, 8'd1, 0);
        for (int k = 6; k < 12; k++) begin
            send_word(16'h3000 + 16'(k));
            expect_out("t3.rest", 1, 16'h3000 + 16'(k), 8'(k - 4), k == 11);
        end

        // Backpressure: pos 4 held, pos 5 dropped with overrun
        for (int k = 0; k < 4; k++) begin
            send_word(16'h4000 + 16'(k));
            expect_out("t4.cp", 0, 16'h0, 8'd0, 0);
        end
        set_ready(1'b0);
        send_word(16'h4004);
        check("t4.hold.count", got_q.size(), 0);
        check("t4.hold.valid", s_if.m_valid, 1);
        check("t4.hold.data",  s_if.m_data,  16'h4004);
        send_word(16'h4005);
        check("t4.ovr",         ovr_cnt,      1);
        check("t4.stall.count", got_q.size(), 0);
        check("t4.stall.data",  s_if.m_data,  16'h4004);
        check("t4.stall.index", s_if.m_index, 0);
        check("t4.stall.valid", s_if.m_valid, 1);
        set_ready(1'b1);
        wait_clk(3);
        expect_out("t4.rel", 1, 16'h4004, 8'd0, 0);
        send_word(16'h4006);
        expect_out("t4.next", 1, 16'h4006, 8'd2, 0);

        // Resync mid-symbol (position 7 pending)
        set_ready(1'b1);
        resync = 1'b1;
        @(posedge clk);
        #1 resync = 1'b0;
        wait_clk(2);
        for (int k = 0; k < 12; k++) begin
            send_word(16'hA000 + 16'(k));
            expect_out("t5", k >= 4, 16'hA000 + 16'(k), 8'(k - 4), k == 11);
        end
        check("t5.ferr", ferr_cnt, 1);
        check("t5.ovr",  ovr_cnt,  1);

        // Reset in the middle of the pos-7 word
        for (int k = 0; k < 6; k++) begin
            send_word(16'hB000 + 16'(k));
            expect_out("t6.pre", k >= 4, 16'hB000 + 16'(k), 8'(k - 4), 0);
        end
        set_ready(1'b0);
        send_word(16'hB006);
        check("t6.held", s_if.m_valid, 1);
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 9; i++) sclk_bit(1'b1);
        mosi = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(1);
        check("t6.rst.valid", s_if.m_valid, 0);
        check("t6.rst.data",  s_if.m_data,  0);
        check("t6.rst.index", s_if.m_index, 0);
        check("t6.rst.last",  s_if.m_last,  0);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(4);
        reset = 1'b1;
        s_if.m_ready = 1'b1;
        wait_clk(6);
        check("t6.noout", got_q.size(), 0);
        for (int k = 0; k < 12; k++) begin
            send_word(16'hC000 + 16'(k));
            expect_out("t6.sym", k >= 4, 16'hC000 + 16'(k), 8'(k - 4), k == 11);
        end
        check("t6.ferr", ferr_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
